// File: rtl/calc_key_sequencer.sv
// Operand/operator entry stage for the calculator ALU: turns one-cycle key strobes into
// stable registered operands, an operator, a result-valid level and a display selector.
module calc_key_sequencer #(
  parameter int unsigned WIDTH          = 4,
  parameter int unsigned RESULT_LATENCY = 1
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             digit_strobe_i,
  input  logic [WIDTH-1:0] digit_i,
  input  logic             op_strobe_i,
  input  logic             op_key_i,
  input  logic             eq_strobe_i,
  input  logic [WIDTH-1:0] alu_result_i,
  output logic [WIDTH-1:0] num1_o,
  output logic [WIDTH-1:0] num2_o,
  output logic             op_selected_o,
  output logic             result_valid_o,
  output logic [1:0]       display_sel_o,
  output logic             key_err_o
);

  localparam int unsigned CntW = (RESULT_LATENCY < 2) ? 1 : $clog2(RESULT_LATENCY + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(RESULT_LATENCY);

  typedef enum logic [1:0] {StA, StB, StWait, StShow} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] num1_q, num1_d;
  logic [WIDTH-1:0] num2_q, num2_d;
  logic             op_q, op_d;
  logic             a_loaded_q, a_loaded_d;
  logic             b_loaded_q, b_loaded_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             key_err_q, key_err_d;
  logic             result_valid_q, result_valid_d;
  logic [1:0]       display_sel_q, display_sel_d;

  logic any_strobe;
  logic dropped;

  assign any_strobe = eq_strobe_i | op_strobe_i | digit_strobe_i;
  // Any strobe below the highest-priority one present is discarded.
  assign dropped    = (eq_strobe_i & (op_strobe_i | digit_strobe_i)) |
                      (op_strobe_i & digit_strobe_i);

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge clear_i) begin
    if (clear_i) begin
      state_q        <= StA;
      num1_q         <= '0;
      num2_q         <= '0;
      op_q           <= 1'b0;
      a_loaded_q     <= 1'b0;
      b_loaded_q     <= 1'b0;
      cnt_q          <= '0;
      key_err_q      <= 1'b0;
      result_valid_q <= 1'b0;
      display_sel_q  <= 2'd0;
    end else begin
      state_q        <= state_d;
      num1_q         <= num1_d;
      num2_q         <= num2_d;
      op_q           <= op_d;
      a_loaded_q     <= a_loaded_d;
      b_loaded_q     <= b_loaded_d;
      cnt_q          <= cnt_d;
      key_err_q      <= key_err_d;
      result_valid_q <= result_valid_d;
      display_sel_q  <= display_sel_d;
    end
  end

  // Next-state and operand update.
  always_comb begin
    state_d    = state_q;
    num1_d     = num1_q;
    num2_d     = num2_q;
    op_d       = op_q;
    a_loaded_d = a_loaded_q;
    b_loaded_d = b_loaded_q;
    cnt_d      = cnt_q;
    key_err_d  = dropped;

    case (state_q)
      StA: begin
        if (eq_strobe_i) begin
          key_err_d = 1'b1;
        end else if (op_strobe_i) begin
          if (a_loaded_q) begin
            op_d       = op_key_i;
            num2_d     = '0;
            b_loaded_d = 1'b0;
            state_d    = StB;
          end else begin
            key_err_d = 1'b1;
          end
        end else if (digit_strobe_i) begin
          num1_d     = digit_i;
          a_loaded_d = 1'b1;
        end
      end

      StB: begin
        if (eq_strobe_i) begin
          if (b_loaded_q) begin
            cnt_d   = CntLoad;
            state_d = StWait;
          end else begin
            key_err_d = 1'b1;
          end
        end else if (op_strobe_i) begin
          op_d = op_key_i;
        end else if (digit_strobe_i) begin
          num2_d     = digit_i;
          b_loaded_d = 1'b1;
        end
      end

      StWait: begin
        if (any_strobe) begin
          key_err_d = 1'b1;
        end
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q <= CntW'(1)) begin
          state_d = StShow;
        end
      end

      StShow: begin
        if (eq_strobe_i) begin
          // Repeat: feed the result back as A, keep B and the operator.
          num1_d  = alu_result_i;
          cnt_d   = CntLoad;
          state_d = StWait;
        end else if (op_strobe_i) begin
          num1_d     = alu_result_i;
          op_d       = op_key_i;
          num2_d     = '0;
          b_loaded_d = 1'b0;
          state_d    = StB;
        end else if (digit_strobe_i) begin
          num1_d     = digit_i;
          num2_d     = '0;
          a_loaded_d = 1'b1;
          b_loaded_d = 1'b0;
          state_d    = StA;
        end
      end

      default: begin
        state_d = StA;
      end
    endcase
  end

  // Status outputs follow the state being entered so they change on the same edge.
  always_comb begin
    result_valid_d = (state_d == StShow);
    display_sel_d  = 2'd0;
    case (state_d)
      StA:     display_sel_d = 2'd0;
      StB:     display_sel_d = 2'd1;
      StWait:  display_sel_d = 2'd1;
      StShow:  display_sel_d = 2'd2;
      default: display_sel_d = 2'd0;
    endcase
  end

  assign num1_o         = num1_q;
  assign num2_o         = num2_q;
  assign op_selected_o  = op_q;
  assign result_valid_o = result_valid_q;
  assign display_sel_o  = display_sel_q;
  assign key_err_o      = key_err_q;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Self-checking bench for calc_key_sequencer: directed scenarios plus randomized key
// traffic compared against a key-level behavioural model of the calculator entry rules.
module tb_calc_key_sequencer;

  localparam int W   = 4;
  localparam int LAT = 1;
  localparam int MSK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         clear = 1'b1;
  logic         digit_strobe = 1'b0;
  logic [W-1:0] digit = '0;
  logic         op_strobe = 1'b0;
  logic         op_key = 1'b0;
  logic         eq_strobe = 1'b0;
  logic [W-1:0] alu_result;
  logic [W-1:0] num1, num2;
  logic         op_selected, result_valid, key_err;
  logic [1:0]   display_sel;

  int checks = 0;
  int errors = 0;

  // Model: mode 0 = entering A, 1 = entering B, 2 = waiting on ALU, 3 = showing result.
  int m_mode, m_num1, m_num2, m_op, m_wait;
  bit m_a, m_b, m_err;

  always #5 clk = ~clk;

  // Simple ALU standing in for the downstream block.
  assign alu_result = op_selected ? W'(num1 - num2) : W'(num1 + num2);

  calc_key_sequencer #(.WIDTH(W), .RESULT_LATENCY(LAT)) dut (
    .clk_i         (clk),
    .clear_i       (clear),
    .digit_strobe_i(digit_strobe),
    .digit_i       (digit),
    .op_strobe_i   (op_strobe),
    .op_key_i      (op_key),
    .eq_strobe_i   (eq_strobe),
    .alu_result_i  (alu_result),
    .num1_o        (num1),
    .num2_o        (num2),
    .op_selected_o (op_selected),
    .result_valid_o(result_valid),
    .display_sel_o (display_sel),
    .key_err_o     (key_err)
  );

  function automatic int model_alu();
    return (m_op != 0 ? m_num1 - m_num2 : m_num1 + m_num2) & MSK;
  endfunction

  function automatic int model_disp();
    return (m_mode == 0) ? 0 : (m_mode == 3) ? 2 : 1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_num1 = 0; m_num2 = 0; m_op = 0; m_wait = 0;
    m_a = 0; m_b = 0; m_err = 0;
  endtask

  task automatic model_key(bit ds, int d, bit os, bit ok, bit es);
    int res;
    res   = model_alu();
    m_err = (int'(ds) + int'(os) + int'(es)) > 1;
    if (m_mode == 2) begin
      if (ds || os || es) m_err = 1;
      m_wait = m_wait - 1;
      if (m_wait == 0) m_mode = 3;
    end else if (es) begin
      if (m_mode == 1 && m_b) begin m_wait = LAT; m_mode = 2; end
      else if (m_mode == 3) begin m_num1 = res; m_wait = LAT; m_mode = 2; end
      else m_err = 1;
    end else if (os) begin
      if (m_mode == 0 && !m_a) m_err = 1;
      else begin
        if (m_mode == 3) m_num1 = res;
        if (m_mode != 1) begin m_num2 = 0; m_b = 0; end
        m_op = ok; m_mode = 1;
      end
    end else if (ds) begin
      if (m_mode == 1) begin m_num2 = d; m_b = 1; end
      else begin
        if (m_mode == 3) begin m_num2 = 0; m_b = 0; end
        m_num1 = d; m_a = 1; m_mode = 0;
      end
    end
  endtask

  // Present one cycle of keys, advance the model at the edge, return 1 ns after it.
  task automatic tick(bit ds, int d, bit os, bit ok, bit es);
    digit_strobe = ds; digit = W'(d); op_strobe = os; op_key = ok; eq_strobe = es;
    @(posedge clk);
    model_key(ds, d, os, ok, es);
    #1;
    digit_strobe = 0; op_strobe = 0; eq_strobe = 0;
  endtask

  task automatic pulse_clear();
    #2 clear = 1'b1;
    #1 clear = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    #3;
    checks++; if (num1 !== 0 || num2 !== 0 || op_selected !== 0) begin
      errors++; $display("FAIL reset_operands: num1=%0d num2=%0d op=%0d, need 0", num1, num2, op_selected); end
    checks++; if (result_valid !== 0 || display_sel !== 0 || key_err !== 0) begin
      errors++; $display("FAIL reset_status: valid=%0d disp=%0d err=%0d, need 0", result_valid, display_sel, key_err); end
    #4 clear = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    tick(1, 3, 0, 0, 0);
    tick(0, 0, 1, 0, 0);
    tick(1, 4, 0, 0, 0);
    tick(0, 0, 0, 0, 1);
    for (int i = 1; i <= LAT; i++) begin
      checks++; if (result_valid !== 0 || display_sel !== 1) begin
        errors++; $display("FAIL basic_wait: valid=%0d disp=%0d, need 0/1", result_valid, display_sel); end
      if (i < LAT) tick(0, 0, 0, 0, 0);
    end
    tick(0, 0, 0, 0, 0);
    checks++; if (result_valid !== 1 || display_sel !== 2) begin
      errors++; $display("FAIL basic_valid: valid=%0d disp=%0d, need 1/2", result_valid, display_sel); end
    checks++; if (num1 !== 3 || num2 !== 4 || op_selected !== 0) begin
      errors++; $display("FAIL basic_operands: %0d %0d %0d, need 3 4 0", num1, num2, op_selected); end
    checks++; if (alu_result !== 7) begin
      errors++; $display("FAIL basic_alu: got %0d need 7", alu_result); end
  endtask

  task automatic test_chain();
    tick(0, 0, 1, 1, 0);
    checks++; if (num1 !== 7 || num2 !== 0 || display_sel !== 1 || result_valid !== 0) begin
      errors++; $display("FAIL chain_op: num1=%0d num2=%0d disp=%0d valid=%0d, need 7 0 1 0",
                         num1, num2, display_sel, result_valid); end
    tick(1, 9, 0, 0, 0);
    tick(0, 0, 0, 0, 1);
    repeat (LAT) tick(0, 0, 0, 0, 0);
    checks++; if (num1 !== 7 || num2 !== 9 || op_selected !== 1 || result_valid !== 1) begin
      errors++; $display("FAIL chain_result: %0d %0d %0d valid=%0d, need 7 9 1 1",
                         num1, num2, op_selected, result_valid); end
    checks++; if (alu_result !== 4'hE) begin
      errors++; $display("FAIL chain_alu: got %0h need e", alu_result); end
  endtask

  task automatic test_errors();
    pulse_clear();
    tick(0, 0, 0, 0, 1);
    checks++; if (key_err !== 1 || display_sel !== 0 || num1 !== 0) begin
      errors++; $display("FAIL err_eq_in_a: err=%0d disp=%0d num1=%0d, need 1 0 0", key_err, display_sel, num1); end
    tick(0, 0, 1, 1, 0);
    checks++; if (key_err !== 1 || display_sel !== 0 || op_selected !== 0) begin
      errors++; $display("FAIL err_op_no_a: err=%0d disp=%0d op=%0d, need 1 0 0", key_err, display_sel, op_selected); end
    tick(0, 0, 0, 0, 0);
    checks++; if (key_err !== 0) begin
      errors++; $display("FAIL err_one_cycle: err=%0d need 0", key_err); end
    tick(1, 6, 0, 0, 0);
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 1);
    checks++; if (key_err !== 1 || display_sel !== 1 || result_valid !== 0 || num1 !== 6 || num2 !== 0) begin
      errors++; $display("FAIL err_eq_no_b: err=%0d disp=%0d valid=%0d num1=%0d num2=%0d, need 1 1 0 6 0",
                         key_err, display_sel, result_valid, num1, num2); end
    tick(0, 0, 1, 1, 0);
    checks++; if (op_selected !== 1 || key_err !== 0 || display_sel !== 1) begin
      errors++; $display("FAIL op_change: op=%0d err=%0d disp=%0d, need 1 0 1", op_selected, key_err, display_sel); end
  endtask

  task automatic test_simultaneous();
    pulse_clear();
    tick(1, 5, 0, 0, 0);
    tick(1, 2, 1, 1, 0);
    checks++; if (key_err !== 1 || num1 !== 5 || num2 !== 0 || op_selected !== 1 || display_sel !== 1) begin
      errors++; $display("FAIL simul_digit_op: err=%0d num1=%0d num2=%0d op=%0d disp=%0d, need 1 5 0 1 1",
                         key_err, num1, num2, op_selected, display_sel); end
  endtask

  task automatic test_repeat();
    tick(1, 2, 0, 0, 0);
    tick(0, 0, 0, 0, 1);
    repeat (LAT) tick(0, 0, 0, 0, 0);
    checks++; if (result_valid !== 1 || alu_result !== 3) begin
      errors++; $display("FAIL repeat_first: valid=%0d alu=%0d, need 1 3", result_valid, alu_result); end
    tick(0, 0, 0, 0, 1);
    checks++; if (num1 !== 3 || num2 !== 2 || op_selected !== 1) begin
      errors++; $display("FAIL repeat_operands: %0d %0d %0d, need 3 2 1", num1, num2, op_selected); end
    for (int i = 1; i <= LAT; i++) begin
      checks++; if (result_valid !== 0) begin
        errors++; $display("FAIL repeat_drop: valid=%0d need 0 at cycle %0d", result_valid, i); end
      if (i < LAT) tick(0, 0, 0, 0, 0);
    end
    tick(0, 0, 0, 0, 0);
    checks++; if (result_valid !== 1 || alu_result !== 1) begin
      errors++; $display("FAIL repeat_result: valid=%0d alu=%0d, need 1 1", result_valid, alu_result); end
  endtask

  task automatic test_clear();
    tick(1, 1, 0, 0, 0);
    tick(0, 0, 1, 0, 0);
    tick(1, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 1);
    #2 clear = 1'b1;
    #1;
    checks++; if (num1 !== 0 || num2 !== 0 || op_selected !== 0 || result_valid !== 0 ||
                  display_sel !== 0 || key_err !== 0) begin
      errors++; $display("FAIL clear_in_wait: %0d %0d %0d %0d %0d %0d, need all 0",
                         num1, num2, op_selected, result_valid, display_sel, key_err); end
    @(posedge clk); #2 clear = 1'b0;
    model_reset();
    tick(1, 3, 0, 0, 0);
    tick(0, 0, 1, 1, 0);
    tick(1, 2, 0, 0, 0);
    #2 clear = 1'b1;
    #1;
    checks++; if (num1 !== 0 || num2 !== 0 || op_selected !== 0 || display_sel !== 0) begin
      errors++; $display("FAIL clear_in_b: %0d %0d %0d disp=%0d, need all 0", num1, num2, op_selected, display_sel); end
    #1 clear = 1'b0;
    model_reset();
    tick(1, 8, 0, 0, 0);
    checks++; if (num1 !== 8 || key_err !== 0 || display_sel !== 0) begin
      errors++; $display("FAIL clear_then_digit: num1=%0d err=%0d disp=%0d, need 8 0 0", num1, key_err, display_sel); end
  endtask

  task automatic test_random();
    bit ds, os, ok, es;
    int d;
    pulse_clear();
    for (int n = 0; n < 600; n++) begin
      ds = ($urandom_range(0, 2) == 0);
      os = ($urandom_range(0, 4) == 0);
      es = ($urandom_range(0, 5) == 0);
      ok = $urandom_range(0, 1);
      d  = $urandom_range(0, MSK);
      tick(ds, d, os, ok, es);
      checks++; if (int'(num1) != m_num1 || int'(num2) != m_num2) begin
        errors++; $display("FAIL rand_operands @%0d: %0d %0d, need %0d %0d", n, num1, num2, m_num1, m_num2); end
      checks++; if (int'(op_selected) != m_op) begin
        errors++; $display("FAIL rand_op @%0d: %0d need %0d", n, op_selected, m_op); end
      checks++; if (result_valid !== (m_mode == 3)) begin
        errors++; $display("FAIL rand_valid @%0d: %0d need %0d", n, result_valid, m_mode == 3); end
      checks++; if (int'(display_sel) != model_disp()) begin
        errors++; $display("FAIL rand_disp @%0d: %0d need %0d", n, display_sel, model_disp()); end
      checks++; if (key_err !== m_err) begin
        errors++; $display("FAIL rand_err @%0d: %0d need %0d", n, key_err, m_err); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_chain();
    test_errors();
    test_simultaneous();
    test_repeat();
    test_clear();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
